iso_power_sequencer: RTL

//   Drives the isolation enable of a switchable power domain, together with its power switch and domain reset.
//   It is the producer side of the iso nets; the domain's inverter tree consumes them as ISO_CONTROL_*.

---
 rtl/iso_power_sequencer_if.sv | 23 ++
 rtl/iso_power_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/iso_power_sequencer_if.sv
// rtl/iso_power_sequencer_if.sv - request, acknowledge and status nets of the power sequencer
interface iso_power_sequencer_if;
    logic       pwr_down_req;
    logic       pwr_up_req;
    logic       pwr_ack;
    logic       iso;
    logic       pwr_en;
    logic       dom_rst;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state;

    modport master (
        output pwr_down_req, pwr_up_req, pwr_ack,
        input  iso, pwr_en, dom_rst, busy, done, err, state
    );

    modport slave (
        input  pwr_down_req, pwr_up_req, pwr_ack,
        output iso, pwr_en, dom_rst, busy, done, err, state
    );
endinterface

// File: rtl/iso_power_sequencer.sv
// rtl/iso_power_sequencer.sv - isolation, power switch and domain reset sequencer
module iso_power_sequencer #(
    parameter int ISO_SETUP   = 4,
    parameter int RST_HOLD    = 8,
    parameter int ISO_HOLD    = 2,
    parameter int ACK_TIMEOUT = 64,
    parameter int CW          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    iso_power_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_PWR_UP  = 3'd1,
        S_RST_REL = 3'd2,
        S_ISO_REL = 3'd3,
        S_ON      = 3'd4,
        S_ISO_ON  = 3'd5,
        S_RST_ON  = 3'd6,
        S_PWR_DN  = 3'd7
    } state_t;

    // Refuse to elaborate with counts that the timer cannot reach
    if (ISO_SETUP < 1 || RST_HOLD < 1 || ISO_HOLD < 1 || ACK_TIMEOUT < 4 ||
        ISO_SETUP > (2**CW - 1) || RST_HOLD > (2**CW - 1) ||
        ISO_HOLD > (2**CW - 1) || ACK_TIMEOUT > (2**CW - 1)) begin : g_param_check
        $error("iso_power_sequencer: timing parameter out of range");
    end

    localparam logic [CW-1:0] ISO_SETUP_LAST = CW'(ISO_SETUP - 1);
    localparam logic [CW-1:0] RST_HOLD_LAST  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] ISO_HOLD_LAST  = CW'(ISO_HOLD - 1);
    localparam logic [CW-1:0] ACK_LAST       = CW'(ACK_TIMEOUT - 1);

    logic          sync1_q;
    logic          sack_q;
    state_t        state_q, state_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          iso_q, pwr_en_q, dom_rst_q, busy_q;

    // {iso, pwr_en, dom_rst, busy} for a state; ERR sits in S_OFF so it shares OFF's outputs
    function automatic logic [3:0] moore_outs(state_t s);
        case (s)
            S_OFF:     moore_outs = 4'b1010;
            S_PWR_UP:  moore_outs = 4'b1111;
            S_RST_REL: moore_outs = 4'b1111;
            S_ISO_REL: moore_outs = 4'b1101;
            S_ON:      moore_outs = 4'b0100;
            S_ISO_ON:  moore_outs = 4'b1101;
            S_RST_ON:  moore_outs = 4'b1111;
            S_PWR_DN:  moore_outs = 4'b1011;
            default:   moore_outs = 4'b1010;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous switch acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sack_q  <= 1'b0;
        end else begin
            sync1_q <= bus.pwr_ack;
            sack_q  <= sync1_q;
        end
    end

    // Next-state, done pulse and timer; ERR freezes everything until rst
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (!err_q) begin
            case (state_q)
                S_OFF: begin
                    if (bus.pwr_up_req) state_d = S_PWR_UP;
                end
                S_PWR_UP: begin
                    if (sack_q) begin
                        state_d = S_RST_REL;
                    end else if (timer_q == ACK_LAST) begin
                        state_d = S_OFF;
                        err_d   = 1'b1;
                    end
                end
                S_RST_REL: begin
                    if (timer_q == RST_HOLD_LAST) state_d = S_ISO_REL;
                end
                S_ISO_REL: begin
                    if (timer_q == ISO_HOLD_LAST) begin
                        state_d = S_ON;
                        done_d  = 1'b1;
                    end
                end
                S_ON: begin
                    if (bus.pwr_down_req) state_d = S_ISO_ON;
                end
                S_ISO_ON: begin
                    if (timer_q == ISO_SETUP_LAST) state_d = S_RST_ON;
                end
                S_RST_ON: begin
                    state_d = S_PWR_DN;
                end
                S_PWR_DN: begin
                    if (!sack_q) begin
                        state_d = S_OFF;
                        done_d  = 1'b1;
                    end else if (timer_q == ACK_LAST) begin
                        state_d = S_OFF;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end

        // Timer restarts on any transition (including into ERR) and saturates in stable states
        if (state_d != state_q || err_d != err_q) begin
            timer_d = '0;
        end else if (timer_q == {CW{1'b1}}) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // FSM register with Moore outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            timer_q   <= '0;
            iso_q     <= 1'b1;
            pwr_en_q  <= 1'b0;
            dom_rst_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            done_q    <= done_d;
            timer_q   <= timer_d;
            {iso_q, pwr_en_q, dom_rst_q, busy_q} <= moore_outs(state_d);
        end
    end

    assign bus.iso     = iso_q;
    assign bus.pwr_en  = pwr_en_q;
    assign bus.dom_rst = dom_rst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.state   = state_q;

endmodule
